// File: rtl/ultrasonic_ranger.sv
// HC-SR04-class ultrasonic ranger: trigger generation, echo timing with
// rise timeout and over-range detection, divider-free cm conversion, and a
// sequential double-dabble feeding three seven-segment digits.
module ultrasonic_ranger #(
  parameter int TRIG_CYC       = 500,
  parameter int CYC_PER_CM     = 2900,
  parameter int MAX_CM         = 400,
  parameter int RISE_TMO       = 50000,
  parameter int PERIOD_CYC     = 3000000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  localparam int DIST_W        = $clog2(MAX_CM + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic              busy,
  output logic [DIST_W-1:0] dist_cm,
  output logic              dist_valid,
  output logic              timeout,
  output logic [6:0]        ones,
  output logic [6:0]        tens,
  output logic [6:0]        hund
);

  // Three BCD digits cover every reportable distance.
  generate
    if (MAX_CM > 999) begin : g_range_chk
      $error("ultrasonic_ranger: MAX_CM must not exceed 999");
    end
  endgenerate

  localparam int PER_W   = $clog2(PERIOD_CYC + 1);
  localparam int SUB_MAX = (CYC_PER_CM > RISE_TMO) ? CYC_PER_CM : RISE_TMO;
  localparam int SUB_W   = $clog2(SUB_MAX + 1);
  localparam int DD_CW   = $clog2(DIST_W + 1);

  localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(PERIOD_CYC - 1);
  localparam logic [PER_W-1:0]  TRIG_LAST = PER_W'(TRIG_CYC - 1);
  localparam logic [SUB_W-1:0]  TMO_LAST  = SUB_W'(RISE_TMO - 1);
  localparam logic [SUB_W-1:0]  CM_LAST   = SUB_W'(CYC_PER_CM - 1);
  localparam logic [DIST_W-1:0] CM_MAX    = DIST_W'(MAX_CM);
  localparam logic [DD_CW-1:0]  DD_STEPS  = DD_CW'(DIST_W);
  localparam logic [DD_CW-1:0]  DD_ONE    = DD_CW'(1);

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t              state;
  logic [PER_W-1:0]    per_cnt;   // cycles since TRIG entry; also times the trigger
  logic [SUB_W-1:0]    sub_cnt;   // rise timeout in WAIT_RISE, cycles-in-cm in MEASURE
  logic [DIST_W-1:0]   cm_cnt;
  logic [DIST_W-1:0]   cm_next;
  logic                sub_wrap;
  logic                echo_s1, echo_s2, echo_d;
  logic                echo_rise, echo_fall;

  // Display conversion state
  logic [DIST_W-1:0]   dd_bin;
  logic [11:0]         dd_bcd;
  logic [DD_CW-1:0]    dd_cnt;
  logic                dd_done;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] p;  // active-high, bit0 = a .. bit6 = g
    case (d)
      4'd0:    p = 7'b0111111;
      4'd1:    p = 7'b0000110;
      4'd2:    p = 7'b1011011;
      4'd3:    p = 7'b1001111;
      4'd4:    p = 7'b1100110;
      4'd5:    p = 7'b1101101;
      4'd6:    p = 7'b1111101;
      4'd7:    p = 7'b0000111;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1101111;
      default: p = 7'b0000000;
    endcase
    return SEG_ACTIVE_LOW ? ~p : p;
  endfunction

  // Add 3 to every BCD digit >= 5 before the next left shift.
  function automatic logic [11:0] dd_adj(input logic [11:0] b);
    logic [11:0] r;
    r = b;
    for (int i = 0; i < 3; i++)
      if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
    return r;
  endfunction

  // Two-flop synchroniser plus one delayed copy for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) {echo_d, echo_s2, echo_s1} <= 3'b000;
    else     {echo_d, echo_s2, echo_s1} <= {echo_s2, echo_s1, echo};
  end

  assign echo_rise = echo_s2 & ~echo_d;
  assign echo_fall = ~echo_s2 & echo_d;
  assign sub_wrap  = (sub_cnt == CM_LAST);

  // cm count including the current cycle, so a fall reports floor(width/CYC_PER_CM).
  always_comb begin
    cm_next = cm_cnt;
    if (sub_wrap) cm_next = cm_cnt + 1'b1;
  end

  // Main measurement FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      trig       <= 1'b0;
      busy       <= 1'b0;
      dist_cm    <= '0;
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      per_cnt    <= '0;
      sub_cnt    <= '0;
      cm_cnt     <= '0;
    end else begin
      dist_valid <= 1'b0;
      timeout    <= 1'b0;
      if (state != IDLE) per_cnt <= per_cnt + 1'b1;
      case (state)
        IDLE: begin
          if (en || start) begin
            state   <= TRIG;
            trig    <= 1'b1;
            busy    <= 1'b1;
            per_cnt <= '0;
          end
        end
        TRIG: begin
          if (per_cnt == TRIG_LAST) begin
            state   <= WAIT_RISE;
            trig    <= 1'b0;
            sub_cnt <= '0;
          end
        end
        WAIT_RISE: begin
          if (echo_rise) begin
            state   <= MEASURE;
            sub_cnt <= '0;
            cm_cnt  <= '0;
          end else if (sub_cnt == TMO_LAST) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end else begin
            sub_cnt <= sub_cnt + 1'b1;
          end
        end
        MEASURE: begin
          sub_cnt <= sub_wrap ? '0 : sub_cnt + 1'b1;
          cm_cnt  <= cm_next;
          // Reaching MAX_CM wins over a simultaneous falling edge.
          if (cm_next == CM_MAX) begin
            timeout <= 1'b1;
            state   <= HOLDOFF;
          end else if (echo_fall) begin
            dist_cm    <= cm_next;
            dist_valid <= 1'b1;
            state      <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          if (per_cnt == PER_LAST) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          trig  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Sequential double-dabble: load after dist_valid, then one shift per bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dd_bin  <= '0;
      dd_bcd  <= '0;
      dd_cnt  <= '0;
      dd_done <= 1'b0;
    end else if (dist_valid) begin
      dd_bin  <= dist_cm;
      dd_bcd  <= '0;
      dd_cnt  <= DD_STEPS;
      dd_done <= 1'b0;
    end else if (dd_cnt != '0) begin
      {dd_bcd, dd_bin} <= {dd_adj(dd_bcd), dd_bin} << 1;
      dd_cnt           <= dd_cnt - 1'b1;
      dd_done          <= (dd_cnt == DD_ONE);
    end else begin
      dd_done <= 1'b0;
    end
  end

  // Digits change only once a conversion has finished, all three together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ones <= seg7(4'd0);
      tens <= seg7(4'd0);
      hund <= seg7(4'd0);
    end else if (dd_done) begin
      ones <= seg7(dd_bcd[3:0]);
      tens <= seg7(dd_bcd[7:4]);
      hund <= seg7(dd_bcd[11:8]);
    end
  end

endmodule

// File: doc/ultrasonic_ranger.md
Name: ultrasonic_ranger

Overview:
Parametrised HC-SR04-class ultrasonic range controller with measurement period enforcement, timeout detection, cm conversion and three-digit seven-segment output. It generates the trigger pulse and times the echo high pulse. It converts the echo width to centimetres without a divider, flags missed or over-range echoes, and drives the board's seven-segment displays. It replaces the fixed-width, free-running ranger and adds reset, single-shot mode, input synchronisation, a valid strobe and a BCD display path.

Parameters:
TRIG_CYC, 500, trigger high width in clk cycles (10 us at 50 MHz)
CYC_PER_CM, 2900, clk cycles of echo-high per centimetre (58 us round trip)
MAX_CM, 400, largest reportable distance; reaching it while echo is high is over-range
RISE_TMO, 50000, max cycles from trigger fall to echo rise
PERIOD_CYC, 3000000, minimum cycles between successive trigger rising edges; must exceed TRIG_CYC+RISE_TMO+MAX_CM*CYC_PER_CM+8
SEG_ACTIVE_LOW, 1, 1 = segment lit when bit is 0
DIST_W, derived = clog2(MAX_CM+1), distance width (9 for default)

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
en  in  1  continuous mode: measure back-to-back while high
start  in  1  single-shot request, one-cycle pulse, honoured only in IDLE
echo  in  1  sensor echo, asynchronous
trig  out  1  sensor trigger, registered
busy  out  1  high in any state but IDLE
dist_cm  out  DIST_W  last valid distance, cm, floor
dist_valid  out  1  one-cycle strobe when dist_cm updates
timeout  out  1  one-cycle strobe on missed/over-range echo
ones  out  7  units digit segments, bit0=a .. bit6=g
tens  out  7  tens digit segments
hund  out  7  hundreds digit segments

Behaviour:
- Reset (async, immediate): trig=0, busy=0, dist_cm=0, dist_valid=0, timeout=0, all digits show "0" (7'b1000000 when SEG_ACTIVE_LOW=1); FSM=IDLE, all counters 0.
- echo passes a 2-flop synchroniser; edges are detected on the synchronised signal, adding 2-3 cycles of latency, which the bench tolerates.
- The period counter clears on TRIG entry and counts every cycle until the next IDLE.
- IDLE: if en=1 or start=1, go to TRIG next cycle; en has priority, and start is ignored outside IDLE.
- TRIG: trig=1 for exactly TRIG_CYC cycles, then go to WAIT_RISE with trig=0.
- WAIT_RISE: on a rising edge of the synchronised echo, go to MEASURE with sub-counter=0 and cm counter=0. After RISE_TMO cycles with no edge, pulse timeout and go to HOLDOFF. An echo already high on entry does not count as an edge.
- MEASURE: the sub-counter increments each cycle; at CYC_PER_CM-1 it wraps to 0 and the cm counter increments.
  - On a falling edge: dist_cm <= cm counter, dist_valid pulses for 1 cycle, go to HOLDOFF.
  - If the cm counter reaches MAX_CM with echo still high: timeout pulses, dist_cm is unchanged, go to HOLDOFF.
  - A falling edge in the same cycle the cm counter reaches MAX_CM counts as over-range.
- HOLDOFF: wait until the period counter = PERIOD_CYC-1, then go to IDLE. Back-to-back trigger rising edges are therefore exactly PERIOD_CYC+1 cycles apart in continuous mode.
- Deasserting en mid-cycle lets the current cycle finish through HOLDOFF, then the FSM stays in IDLE.
- dist_valid and timeout are never both high in a cycle; neither is high in IDLE.
- Display path: a sequential double-dabble starts the cycle after dist_valid. ones/tens/hund update together exactly DIST_W+2 cycles after dist_valid and are otherwise stable. A new dist_valid during a conversion restarts it with the new value.
- Values above 999 cannot occur since MAX_CM ≤ 999; elaboration fails if MAX_CM > 999.
- Counter widths are sized from the parameters, and no counter wraps unintentionally.

Test Plan:
Bench parameters: TRIG_CYC=5, CYC_PER_CM=10, MAX_CM=400, RISE_TMO=50, PERIOD_CYC=5000, SEG_ACTIVE_LOW=1.
- Reset: assert rst mid-sim -> trig=0, busy=0, dist_cm=0, ones/tens/hund=7'b1000000 the same cycle.
- en=1; echo rises 3 cycles after trig falls and stays high 1234 cycles -> trig high exactly 5 cycles, dist_valid once, dist_cm=123. Then hund=7'b1111001, tens=7'b0100100, ones=7'b0110000, DIST_W+2=11 cycles after dist_valid.
- en=1, echo held 0 -> timeout pulse ~50 cycles after trig fall, dist_cm stays 123, next trig rise exactly 5001 cycles after previous; no dist_valid.
- Echo high 4500 cycles -> timeout when cm counter hits 400, dist_cm unchanged, no dist_valid; echo stuck high entering WAIT_RISE -> timeout after 50 cycles.
- en=0, start pulse -> one 5-cycle trig, busy high until HOLDOFF ends. A second start while busy is ignored, with no further trig.
- rst asserted during MEASURE (echo high) -> trig=0, busy=0 immediately, no dist_valid/timeout. After release with en=1, a normal cycle completes correctly.
